// File: rtl/ext_ram_reader.sv
// ext_ram_reader
//   Read-out sequencer for the PE_BLOCK extrinsic RAM. Sweeps base_addr ..
//   base_addr+len-1 (wrapping modulo RAM_DEPTH), issues one-cycle-latency
//   reads on the EXT_RAM port, and streams each word with its source address
//   over a valid/ready interface. Read latency is absorbed by a 2-entry skid
//   FIFO placed in front of a registered output stage.
//
//   Optional feature macro: EXT_READ_CHECK_EN
//     When defined, adds err / err_count outputs. Every transferred word is
//     compared lane-by-lane with out_addr[MESSAGE_WIDTH-1:0]. Any mismatch sets
//     the sticky err flag and bumps err_count (saturating). Both clear on an
//     accepted start and on reset.
//
//   Ports
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     start             one-cycle sweep request, sampled only in IDLE
//     base_addr, len    first address and word count (0..RAM_DEPTH)
//     abort             cancel sweep, flush buffered/in-flight data
//     busy, done        sweep in progress / one-cycle completion pulse
//     address, ext_cs   EXT_RAM read port (ext_we tied low)
//     ext_we
//     ext_data_out      EXT_RAM read data, valid the cycle after ext_cs
//     out_valid/ready   output stream handshake
//     out_data          three message lanes {[2],[1],[0]}
//     out_addr          address the word was read from
//     err, err_count    checker outputs (EXT_READ_CHECK_EN only)
module ext_ram_reader #(
  parameter int MESSAGE_WIDTH = 5,
  parameter int ADDR_WIDTH    = 8,
  parameter int RAM_DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [ADDR_WIDTH:0]        len,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH-1:0]      address,
  output logic                       ext_cs,
  output logic                       ext_we,
  input  logic [3*MESSAGE_WIDTH-1:0] ext_data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3*MESSAGE_WIDTH-1:0] out_data,
`ifdef EXT_READ_CHECK_EN
  output logic                       err,
  output logic [ADDR_WIDTH:0]        err_count,
`endif
  output logic [ADDR_WIDTH-1:0]      out_addr
);

  localparam int DW = 3 * MESSAGE_WIDTH;
  localparam int LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LW-1:0]         remaining;

  // One read can be in flight at a time; its address travels alongside it
  logic                  rd_pending;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic [DW-1:0]         fifo_data [2];
  logic [ADDR_WIDTH-1:0] fifo_tag  [2];
  logic                  fifo_wptr, fifo_rptr;
  logic [1:0]            fifo_count;

  logic accept_start, credit_ok, issue;
  logic out_free, fifo_pop, fifo_push, bypass;

  assign accept_start = (state == IDLE) && start && !abort;

  // The output register is not counted: in steady state a word sits there
  // while the FIFO is empty, so one read can be issued every cycle.
  assign credit_ok = (fifo_count + {1'b0, rd_pending}) < 2'd2;
  assign issue     = (state == READ) && !abort && credit_ok;

  assign out_free  = !out_valid || out_ready;
  assign fifo_pop  = out_free && (fifo_count != 2'd0);
  // Returning data skips the FIFO when it is empty and the output can take it
  assign bypass    = out_free && (fifo_count == 2'd0) && rd_pending;
  assign fifo_push = rd_pending && !bypass;

  assign address = cur_addr;
  assign ext_we  = 1'b0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; abort overrides everything, including a same-cycle start
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = (len == '0) ? DONE : READ;
      READ:  if (issue && (remaining == LW'(1))) next_state = DRAIN;
      DRAIN: if ((fifo_count == 2'd0) && !rd_pending && out_free) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // Control outputs decoded from state
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    ext_cs = 1'b0;
    case (state)
      READ:  begin
        busy   = 1'b1;
        ext_cs = issue;
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Sweep address/count, read tracking, FIFO bookkeeping and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      remaining  <= '0;
      rd_pending <= 1'b0;
      rd_addr    <= '0;
      fifo_wptr  <= 1'b0;
      fifo_rptr  <= 1'b0;
      fifo_count <= 2'd0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
    end else begin
      if (accept_start) begin
        cur_addr  <= base_addr;
        remaining <= len;
      end else if (issue) begin
        cur_addr  <= (cur_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : cur_addr + 1'b1;
        remaining <= remaining - LW'(1);
      end

      rd_pending <= issue;
      if (issue) rd_addr <= cur_addr;

      if (abort) begin
        rd_pending <= 1'b0;
        fifo_wptr  <= 1'b0;
        fifo_rptr  <= 1'b0;
        fifo_count <= 2'd0;
        out_valid  <= 1'b0;
      end else begin
        if (out_free) begin
          if (fifo_count != 2'd0) begin
            out_valid <= 1'b1;
            out_data  <= fifo_data[fifo_rptr];
            out_addr  <= fifo_tag[fifo_rptr];
          end else if (rd_pending) begin
            out_valid <= 1'b1;
            out_data  <= ext_data_out;
            out_addr  <= rd_addr;
          end else begin
            out_valid <= 1'b0;
          end
        end

        if (fifo_push) fifo_wptr <= ~fifo_wptr;
        if (fifo_pop)  fifo_rptr <= ~fifo_rptr;
        case ({fifo_push, fifo_pop})
          2'b10:   fifo_count <= fifo_count + 2'd1;
          2'b01:   fifo_count <= fifo_count - 2'd1;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // FIFO storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (fifo_push && !abort) begin
      fifo_data[fifo_wptr] <= ext_data_out;
      fifo_tag[fifo_wptr]  <= rd_addr;
    end
  end

`ifdef EXT_READ_CHECK_EN
  logic lane_mismatch;

  always_comb begin
    lane_mismatch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_data[i*MESSAGE_WIDTH +: MESSAGE_WIDTH] != out_addr[MESSAGE_WIDTH-1:0])
        lane_mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (accept_start) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (out_valid && out_ready && lane_mismatch) begin
      err <= 1'b1;
      if (err_count != '1) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ext_ram_reader.sv
// tb_ext_ram_reader
//   Directed testbench for ext_ram_reader. A behavioural EXT_RAM (one-cycle
//   read latency, preloaded with data lanes equal to the low address bits)
//   feeds the DUT; a negedge monitor logs every stream transfer, done pulse
//   and read issue, and each test task compares the log against hand-derived
//   expectations.
module tb_ext_ram_reader;

  localparam int MW = 5;
  localparam int AW = 8;
  localparam int DW = 3 * MW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] address;
  logic          ext_cs;
  logic          ext_we;
  logic [DW-1:0] ext_data_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
`ifdef EXT_READ_CHECK_EN
  logic          err;
  logic [AW:0]   err_count;
`endif

  int total;
  int bad;

  ext_ram_reader #(.MESSAGE_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .len          (len),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .address      (address),
    .ext_cs       (ext_cs),
    .ext_we       (ext_we),
    .ext_data_out (ext_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
`ifdef EXT_READ_CHECK_EN
    .err          (err),
    .err_count    (err_count),
`endif
    .out_addr     (out_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural EXT_RAM: data valid the cycle after chip select
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ext_cs) ext_data_out <= mem[address];
  end

  int cyc;
  always @(posedge clk) cyc++;

  // Monitor: logs stream transfers and counts control events
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  int            cyc_q[$];
  int            done_cnt, cs_cnt, issued, xfered, credit_viol, stall_viol;
  bit            prev_hold;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (ext_cs) begin
        if (issued - xfered > 2) credit_viol++;
        issued++;
        cs_cnt++;
      end
      if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_data || out_addr !== prev_addr))
        stall_viol++;
      if (out_valid && out_ready) begin
        addr_q.push_back(out_addr);
        data_q.push_back(out_data);
        cyc_q.push_back(cyc);
        xfered++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_addr = out_addr;
    end
  end

  task automatic clear_mon();
    addr_q.delete();
    data_q.delete();
    cyc_q.delete();
    done_cnt    = 0;
    cs_cnt      = 0;
    issued      = 0;
    xfered      = 0;
    credit_viol = 0;
    stall_viol  = 0;
    prev_hold   = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit seen);
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; len = '0;
    idle_cycles(3);
    total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    total++; if (address !== '0)     begin bad++; $display("[TB] FAIL reset_address got=%0d want=0", address); end
    total++; if (ext_cs !== 1'b0)    begin bad++; $display("[TB] FAIL reset_ext_cs got=%b want=0", ext_cs); end
    total++; if (ext_we !== 1'b0)    begin bad++; $display("[TB] FAIL reset_ext_we got=%b want=0", ext_we); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0)    begin bad++; $display("[TB] FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (out_addr !== '0)    begin bad++; $display("[TB] FAIL reset_out_addr got=%0d want=0", out_addr); end
    rst_n = 1'b1;
    idle_cycles(2);
    clear_mon();
  endtask

  // Shared body for full-rate sweeps: words, order, data, gaps, one done
  task automatic test_sweep(input string name, input logic [AW-1:0] b, input int l);
    bit            seen;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            gaps;
    clear_mon();
    out_ready = 1'b1;
    pulse_start(b, (AW+1)'(l));
    wait_done(l + 40, seen);
    total++; if (!seen) begin bad++; $display("[TB] FAIL %s_done_timeout got=none want=pulse", name); end
    total++; if (addr_q.size() != l) begin bad++; $display("[TB] FAIL %s_count got=%0d want=%0d", name, addr_q.size(), l); end
    gaps = 0;
    for (int i = 0; i < addr_q.size() && i < l; i++) begin
      ea = AW'(int'(b) + i);
      ed = {3{ea[MW-1:0]}};
      total++;
      if (addr_q[i] !== ea || data_q[i] !== ed) begin
        bad++;
        $display("[TB] FAIL %s_word%0d got addr=%0d data=%h want addr=%0d data=%h", name, i, addr_q[i], data_q[i], ea, ed);
      end
      if (i > 0 && cyc_q[i] != cyc_q[i-1] + 1) gaps++;
    end
    total++; if (gaps != 0)     begin bad++; $display("[TB] FAIL %s_back_to_back got gaps=%0d want=0", name, gaps); end
    total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL %s_done_pulses got=%0d want=1", name, done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL %s_busy_after got=%b want=0", name, busy); end
    total++; if (ext_we !== 1'b0) begin bad++; $display("[TB] FAIL %s_ext_we got=%b want=0", name, ext_we); end
  endtask

  task automatic test_backpressure();
    bit pat [4];
    int k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_mon();
    pulse_start(8'd40, 9'd8);
    k = 0;
    while (done_cnt == 0 && k < 200) begin
      out_ready = pat[k % 4];
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL bp_done got=%0d want=1", done_cnt); end
    total++; if (addr_q.size() != 8) begin bad++; $display("[TB] FAIL bp_count got=%0d want=8", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 8; i++) begin
      total++;
      if (addr_q[i] !== AW'(40 + i) || data_q[i] !== {3{5'(40 + i)}}) begin
        bad++;
        $display("[TB] FAIL bp_word%0d got addr=%0d data=%h want addr=%0d", i, addr_q[i], data_q[i], 40 + i);
      end
    end
    total++; if (stall_viol != 0)  begin bad++; $display("[TB] FAIL bp_stall_stable got=%0d want=0", stall_viol); end
    total++; if (credit_viol != 0) begin bad++; $display("[TB] FAIL bp_credit got=%0d want=0", credit_viol); end
    total++; if (cs_cnt != 8)      begin bad++; $display("[TB] FAIL bp_reads got=%0d want=8", cs_cnt); end
  endtask

  task automatic test_abort();
    int  k;
    int  held;
    bit  seen;
    clear_mon();
    out_ready = 1'b1;
    pulse_start(8'd100, 9'd20);
    k = 0;
    while (xfered < 3 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    total++; if (xfered < 3) begin bad++; $display("[TB] FAIL abort_reach3 got=%0d want=3", xfered); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
    held = addr_q.size();
    idle_cycles(6);
    total++; if (addr_q.size() != held) begin bad++; $display("[TB] FAIL abort_no_more got=%0d want=%0d", addr_q.size(), held); end
    total++; if (done_cnt != 0) begin bad++; $display("[TB] FAIL abort_no_done got=%0d want=0", done_cnt); end
    for (int i = 0; i < addr_q.size(); i++) begin
      total++;
      if (addr_q[i] !== AW'(100 + i)) begin bad++; $display("[TB] FAIL abort_word%0d got=%0d want=%0d", i, addr_q[i], 100 + i); end
    end
    clear_mon();
    pulse_start(8'd0, 9'd4);
    wait_done(40, seen);
    total++; if (!seen) begin bad++; $display("[TB] FAIL abort_restart_done got=none want=pulse"); end
    total++; if (addr_q.size() != 4) begin bad++; $display("[TB] FAIL abort_restart_count got=%0d want=4", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 4; i++) begin
      total++;
      if (addr_q[i] !== AW'(i) || data_q[i] !== {3{5'(i)}}) begin
        bad++;
        $display("[TB] FAIL abort_restart_word%0d got addr=%0d data=%h want addr=%0d", i, addr_q[i], data_q[i], i);
      end
    end
  endtask

  task automatic test_len_zero();
    clear_mon();
    pulse_start(8'd77, 9'd0);
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL len0_done got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL len0_busy got=%b want=0", busy); end
    idle_cycles(1);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL len0_done_once got=%b want=0", done); end
    idle_cycles(3);
    total++; if (cs_cnt != 0)        begin bad++; $display("[TB] FAIL len0_no_read got=%0d want=0", cs_cnt); end
    total++; if (addr_q.size() != 0) begin bad++; $display("[TB] FAIL len0_no_words got=%0d want=0", addr_q.size()); end
  endtask

  task automatic test_start_while_busy();
    bit seen;
    clear_mon();
    out_ready = 1'b1;
    pulse_start(8'd0, 9'd6);
    base_addr = 8'd200; len = 9'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, seen);
    idle_cycles(6);
    total++; if (!seen) begin bad++; $display("[TB] FAIL busy_start_done got=none want=pulse"); end
    total++; if (addr_q.size() != 6) begin bad++; $display("[TB] FAIL busy_start_count got=%0d want=6", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 6; i++) begin
      total++;
      if (addr_q[i] !== AW'(i)) begin bad++; $display("[TB] FAIL busy_start_word%0d got=%0d want=%0d", i, addr_q[i], i); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL busy_start_done_cnt got=%0d want=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_start_idle got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    out_ready = 1'b1;
    pulse_start(8'd30, 9'd20);
    idle_cycles(4);
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (address !== '0)     begin bad++; $display("[TB] FAIL rstmid_address got=%0d want=0", address); end
    total++; if (ext_cs !== 1'b0)    begin bad++; $display("[TB] FAIL rstmid_ext_cs got=%b want=0", ext_cs); end
    idle_cycles(2);
    rst_n = 1'b1;
    clear_mon();
    idle_cycles(5);
    total++; if (cs_cnt != 0 || addr_q.size() != 0) begin
      bad++; $display("[TB] FAIL rstmid_quiet got reads=%0d words=%0d want 0/0", cs_cnt, addr_q.size());
    end
  endtask

`ifdef EXT_READ_CHECK_EN
  task automatic test_checker();
    bit            seen;
    logic [DW-1:0] saved;
    saved = mem[5];
    mem[5][2*MW-1:MW] = mem[5][2*MW-1:MW] ^ 5'h1F;
    clear_mon();
    out_ready = 1'b1;
    pulse_start(8'd0, 9'd16);
    wait_done(60, seen);
    mem[5] = saved;
    total++; if (err !== 1'b1)         begin bad++; $display("[TB] FAIL chk_err got=%b want=1", err); end
    total++; if (err_count !== 9'd1)   begin bad++; $display("[TB] FAIL chk_err_count got=%0d want=1", err_count); end
    pulse_start(8'd0, 9'd2);
    total++; if (err !== 1'b0)         begin bad++; $display("[TB] FAIL chk_clear got=%b want=0", err); end
    wait_done(40, seen);
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    for (int a = 0; a < 256; a++) mem[a] = {3{5'(a)}};
    test_reset();
    test_sweep("basic", 8'd0, 16);
    test_sweep("wrap", 8'd250, 10);
    test_backpressure();
    test_abort();
    test_len_zero();
    test_start_while_busy();
    test_sweep("full", 8'd0, 256);
    test_reset_mid();
`ifdef EXT_READ_CHECK_EN
    test_checker();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a task stalls beyond its own bounds
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=hung want=finished");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
